// File: rtl/frame_stream_source_if.sv
// frame_stream_source_if: ready/valid pixel stream with packet framing.
//   valid_out          source -> sink  beat valid
//   ready_in           sink -> source  sink ready (readyLatency 0)
//   startofpacket_out  source -> sink  first pixel of a frame
//   endofpacket_out    source -> sink  last pixel of a frame
//   data_out           source -> sink  RGB444 pixel {R,G,B}
interface frame_stream_source_if #(
  parameter int DATA_W = 12
);
  logic              valid_out;
  logic              ready_in;
  logic              startofpacket_out;
  logic              endofpacket_out;
  logic [DATA_W-1:0] data_out;

  modport master (
    output valid_out, startofpacket_out, endofpacket_out, data_out,
    input  ready_in
  );

  modport slave (
    input  valid_out, startofpacket_out, endofpacket_out, data_out,
    output ready_in
  );
endinterface

// File: rtl/frame_stream_source.sv
// frame_stream_source: reads a stored frame from a synchronous frame-buffer
// RAM in raster order and emits it as one ready/valid packet per frame.
// A 2-entry skid FIFO absorbs the RAM's 1-cycle read latency so the stream
// sustains one pixel per cycle under any backpressure pattern.
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   start       request one frame (only honoured while idle)
//   continuous  at frame end, roll straight into the next frame
//   rd_en       RAM read strobe
//   rd_addr     RAM read address
//   rd_data     RAM read data, valid 1 cycle after rd_en
//   busy        streaming in progress
//   frame_done  1-cycle pulse after the eop beat is accepted
//   st          pixel stream (master side)
module frame_stream_source #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic                 busy,
  output logic                 frame_done,
  frame_stream_source_if.master st
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  // One spare bit so the "all N issued" value is distinct from 0.
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [CNT_W-1:0]  FRAME_LEN = CNT_W'(N);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;   // reads issued for the frame being fetched
  logic [CNT_W-1:0]  beat_cnt;    // beats accepted in the frame being emitted
  logic              in_flight;   // read issued last cycle, data on rd_data now
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [1:0]        occ_after;
  logic              pop, push, eop_xfer, room;

  assign st.valid_out         = (fifo_cnt != 2'd0);
  assign st.data_out          = fifo_mem[rd_ptr];
  assign st.startofpacket_out = st.valid_out && (beat_cnt == '0);
  assign st.endofpacket_out   = st.valid_out && (beat_cnt == LAST_BEAT);

  assign pop      = st.valid_out && st.ready_in;
  assign push     = in_flight && (state == STREAM);
  assign eop_xfer = pop && (beat_cnt == LAST_BEAT);

  // Credit for the beat leaving this cycle lets a read issue into the slot it
  // frees; without it the pipeline would bubble every other cycle.
  assign occ_after = fifo_cnt - {1'b0, pop};
  assign room      = (occ_after + {1'b0, in_flight}) < 2'd2;

  // Once the whole frame is issued, only continuous mode may prefetch the next.
  assign rd_en = (state == STREAM) && ((issue_cnt != FRAME_LEN) || continuous) && room;

  // NOTE: all state here uses non-blocking assignments; where two branches
  // assign the same register, the later one in program order wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      rd_addr     <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      in_flight   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      // NOTE: the FIFO storage is reset because its head drives data_out
      // directly, which must read 0 out of reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      frame_done <= eop_xfer;
      in_flight  <= rd_en;

      if (rd_en) begin
        rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
        // A read issued with the count parked at N is pixel 0 of the next frame.
        issue_cnt <= (issue_cnt == FRAME_LEN) ? CNT_W'(1) : issue_cnt + CNT_W'(1);
      end

      if (push) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
      end

      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            rd_addr   <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
          end
        end
        STREAM: begin
          if (eop_xfer && !continuous) begin
            // Flush anything prefetched while continuous was still high.
            state     <= IDLE;
            busy      <= 1'b0;
            rd_addr   <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            in_flight <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The issue rule guarantees a slot for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fifo_cnt == 2'd2)));

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Streaming source for the 12-bit RGB444 video pipeline: reads a stored frame from a synchronous frame-buffer RAM and emits it as one ready/valid packet per frame, with startofpacket/endofpacket framing.
- Drives the input side of the filter chain (e.g. blurring_filter) and honours the sink's ready backpressure.
- Absorbs the RAM's 1-cycle read latency with an internal 2-entry skid FIFO, so it sustains 1 pixel/cycle.

Parameters:
- IMG_WIDTH, 320, pixels per line
- IMG_HEIGHT, 240, lines per frame
- DATA_W, 12, pixel width ({R[11:8],G[7:4],B[3:0]})
- ADDR_W, 17, RAM address width (must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to stream one frame; sampled only in IDLE
- continuous  in  1  when high at frame end, start the next frame with no gap
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address, raster order
- rd_data  in  DATA_W  RAM data; valid exactly 1 cycle after rd_en
- ready_in  in  1  sink ready, readyLatency 0
- valid_out  out  1  output beat valid
- startofpacket_out  out  1  high on pixel 0 of a frame
- endofpacket_out  out  1  high on pixel IMG_WIDTH*IMG_HEIGHT-1
- data_out  out  DATA_W  pixel
- busy  out  1  high from the cycle after start is accepted until frame_done
- frame_done  out  1  one-cycle pulse, the cycle after the eop beat is accepted

Behaviour:
- Reset values: every output is 0 (rd_en, rd_addr, valid_out, sop, eop, data_out, busy, frame_done).
- Reset clears all state:
  - FIFO emptied, all counters zeroed, FSM returns to IDLE.
  - No partial eop is produced.
  - Reset wins over every other input on the same edge.
- Transfer rule: a beat transfers on an edge where valid_out && ready_in.
- Backpressure: while valid_out && !ready_in, data_out, sop and eop are held stable and valid_out stays high.
- FSM states:
  - IDLE: start=1 -> STREAM. Issue-address counter and output-beat counter both load 0.
  - STREAM: issue reads and emit beats. When the eop beat transfers:
    - continuous=1 -> remain in STREAM (counters wrap to 0).
    - else -> IDLE.
- Read issue rule:
  - rd_en=1 when all three hold: in STREAM, issue count < IMG_WIDTH*IMG_HEIGHT for the current frame, and (FIFO occupancy + in-flight read) < 2.
  - rd_addr increments after each issued read.
  - After address IMG_WIDTH*IMG_HEIGHT-1, rd_addr wraps to 0. Next-frame reads may issue before the current eop beat drains only if continuous=1 at issue time; otherwise issuing stops.
- Write-back: rd_data is written into the FIFO the cycle after rd_en. The head of the FIFO drives the outputs.
- Latency:
  - With ready_in held high, rd_en first asserts in the cycle after start is sampled.
  - valid_out first asserts 2 cycles after the start edge.
  - Steady state is 1 beat per cycle with no bubbles, including across frame boundaries in continuous mode.
- Framing:
  - Output-beat counter 0 .. N-1, where N = IMG_WIDTH*IMG_HEIGHT.
  - sop=1 on beat 0 only; eop=1 on beat N-1 only.
  - The counter advances only on transfer.
- frame_done: 1-cycle pulse in the cycle after the eop transfer, also produced in continuous mode.
- busy: falls in the same cycle frame_done pulses, unless continuous kept the FSM in STREAM.
- start while busy: ignored, with no effect on counters or output.
- continuous dropped mid-frame: the current frame completes normally, then the FSM goes to IDLE.
- FIFO: never overflows, by construction of the issue rule. An underflow condition (valid_out=1 with an empty FIFO) is an assertion failure.
- Width rules: counters sized ceil(log2(N))+1 so the terminal compare does not alias. data_out is passed through unmodified, with no arithmetic.

Test Plan:
- Load RAM[a]=a[11:0]; pulse start; hold ready_in=1 -> valid_out at cycle 2; 76800 consecutive beats with data_out=beat index[11:0]; sop only on beat 0; eop only on beat 76799 (data 0xBFF); frame_done pulses 1 cycle later; busy returns to 0.
- Same frame with random ready_in (50% duty) -> identical data/sop/eop sequence; outputs stable during every stall; no beat lost or duplicated; rd_addr never more than 2 ahead of the accepted beats.
- IMG_WIDTH=4, IMG_HEIGHT=3, continuous=1, ready_in=1 -> beats 0..11, 0..11 with no idle cycle between; frame_done after each eop; drop continuous during frame 2 -> IDLE after its eop.
- start re-pulsed at beat 5 of a 12-pixel frame -> no restart, sequence unchanged, one frame_done only.
- reset asserted at beat 7 with ready_in=0 -> next cycle all outputs 0 and FSM in IDLE; a subsequent start produces a fresh frame beginning with sop and data 0x000.
- ready_in=0 from start for 10 cycles -> valid_out=1 with sop=1, data 0x000 held; exactly 2 reads issued (rd_addr 0,1) then rd_en stays 0 until ready_in rises.
